dvd_motion_ctrl: RTL
====================

// Module: dvd_motion_ctrl
// PURPOSE
// - Sequences the bouncing one-pixel "DVD" sprite: turns the raw vsync from hvsync_generator into frame ticks
//   and steps the sprite position at a programmable rate, with pause and restart.
// - Reports bounce and corner-hit events and keeps a colour index that the pixel mux uses.
// - Sits between hvsync_generator and the pixel compare/colour logic in the top level.
// - Replaces clocking logic from posedge vsync: everything runs on clk.
// PARAMETERS
// - GRID_W     20  sprite columns (cell = 32 px); legal x is 0..GRID_W-1
// - GRID_H     15  sprite rows; legal y is 0..GRID_H-1
// - X_W        5   pos_x width
// - Y_W        4   pos_y width
// - START_X    10  x after reset/restart
// - START_Y    7   y after reset/restart
// - VS_ACTIVE  0   active level of vsync; frame tick = transition into this level
// PORTS
// - clk          in   1    pixel clock
// - reset        in   1    asynchronous, active-high reset
// - vsync        in   1    raw vsync from hvsync_generator (clk domain, no synchroniser)
// - cfg_speed    in   4    frames per step minus 1 (0 = step every frame)
// - cfg_pause    in   1    level; when high, freeze the frame count and position
// - cfg_restart  in   1    1-cycle pulse; return to start state
// - pos_x        out  X_W  sprite column
// - pos_y        out  Y_W  sprite row
// - dir_x        out  1    1 = moving right
// - dir_y        out  1    1 = moving down
// - step_strobe  out  1    1-cycle pulse when pos/dir were updated
// - bounce       out  1    1-cycle pulse, qualified by step_strobe, when any direction flipped
// - corner       out  1    1-cycle pulse when both directions flipped in the same step
// - color_idx    out  3    increments (mod 8) on every bounce; +1 only on a corner
// BEHAVIOUR
// - Reset values: pos_x=START_X, pos_y=START_Y, dir_x=1, dir_y=1, color_idx=0, all pulses 0,
//   frame_cnt=0, vs_q=~VS_ACTIVE, state=IDLE.
// - Frame tick: registered vs_q; tick = (vsync==VS_ACTIVE) && (vs_q!=VS_ACTIVE). There is exactly one tick per frame.
// - FSM states: IDLE, MOVE, REPORT.
//   - IDLE: on tick with !cfg_pause:
//     - if frame_cnt >= cfg_speed: frame_cnt <= 0 and go to MOVE.
//     - else: frame_cnt <= frame_cnt + 1.
//     - A tick under pause is ignored.
//   - MOVE (1 cycle): compute next state per axis.
//     - If dir=1 and pos==max (GRID-1): dir flips and pos holds.
//     - If dir=0 and pos==0: dir flips and pos holds.
//     - Otherwise pos = pos ± 1.
//     - Register the results and the flip flags. Go to REPORT.
//   - REPORT (1 cycle): step_strobe=1, bounce=flip_x|flip_y, corner=flip_x&flip_y.
//     - color_idx += bounce (wraps 7->0). Return to IDLE.
// - Latency: tick sampled in cycle N -> MOVE in N+1 -> pos/dir visible and pulses high in N+2.
// - Pulses are registered and high for exactly 1 cycle.
// - Bounce is a flip-in-place step: the position does not move on the frame it bounces (pos 19 -> 19 with dir 1->0).
// - cfg_speed compare uses >=. Lowering cfg_speed below the current frame_cnt gives a step on the next tick.
// - cfg_restart:
//   - Synchronous; highest priority in any state.
//   - Loads the reset values except color_idx, which holds. Goes to IDLE with no pulses that cycle.
//   - A tick arriving in the same cycle is dropped.
// - cfg_pause asserted in MOVE/REPORT does not abort the step in flight.
// - Out-of-range pos (impossible by construction): treat >= max as max and <= 0 as 0.
// - Async reset mid-step: all state returns to reset values immediately; no partial pulse.
// - Width: X_W/Y_W must hold GRID-1. Arithmetic is unsigned and never wraps, because the bounds are checked first.
// STRUCTURE
// - Shared package dvd_pkg holds:
//   - state enum {IDLE, MOVE, REPORT}
//   - GRID_W/GRID_H/START_X/START_Y defaults
//   - the X_W/Y_W localparams
// - One sub-module: dvd_frame_tick, which contains the vsync edge detector and the frame_cnt divider
//   with pause/restart. It outputs step_req as a 1-cycle pulse.
// - The per-axis bounce step is a function in dvd_pkg, reused for x and y.
// TESTING
// - Reset, cfg_speed=0, 3 vsync frames:
//   - pos 10,7 -> 11,8 -> 12,9 -> 13,10.
//   - step_strobe exactly 2 clk after each vsync active edge.
// - Right/bottom edge, starting from x=19, dir_x=1, y=14, dir_y=1, one tick:
//   - pos stays 19,14; dir 0,0.
//   - bounce=1, corner=1, color_idx +1.
//   - Next tick: pos 18,13.
// - cfg_speed=3:
//   - step only on ticks 4, 8, 12.
//   - Changing to 0 while frame_cnt=2 -> step on the very next tick.
// - cfg_pause held 5 frames:
//   - no step_strobe, pos/frame_cnt frozen.
//   - Release -> stepping resumes from the frozen count.
// - cfg_restart in the same cycle as a tick, with pos=3,2 and color_idx=5:
//   - pos 10,7; dir 1,1; color_idx 5; no pulse.
// - Async reset asserted in the MOVE cycle:
//   - outputs immediately at reset values, step_strobe never asserts.
//   - Left/top bounce at 0,0 with dir 0,0 -> corner=1.

Source files
------------

// File: rtl/dvd_pkg.sv
// Shared types, defaults and the per-axis bounce step for the DVD sprite motion controller.
package dvd_pkg;

    localparam int   DEF_GRID_W    = 20;
    localparam int   DEF_GRID_H    = 15;
    localparam int   DEF_START_X   = 10;
    localparam int   DEF_START_Y   = 7;
    localparam logic DEF_VS_ACTIVE = 1'b0;

    localparam int X_W     = 5;
    localparam int Y_W     = 4;
    localparam int AXIS_W  = (X_W > Y_W) ? X_W : Y_W;
    localparam int SPEED_W = 4;
    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        REPORT
    } state_t;

    typedef struct packed {
        logic [AXIS_W-1:0] pos;
        logic              dir;
        logic              flip;
    } axis_t;

    // A bounce flips direction in place; out-of-range positions are clamped to the edge first.
    function automatic axis_t axis_step(input logic [AXIS_W-1:0] pos,
                                        input logic              dir,
                                        input logic [AXIS_W-1:0] max_pos);
        axis_t             r;
        logic [AXIS_W-1:0] p;
        p      = (pos > max_pos) ? max_pos : pos;
        r.pos  = p;
        r.dir  = dir;
        r.flip = 1'b0;
        if (dir && (p == max_pos)) begin
            r.dir  = 1'b0;
            r.flip = 1'b1;
        end else if (!dir && (p == '0)) begin
            r.dir  = 1'b1;
            r.flip = 1'b1;
        end else if (dir) begin
            r.pos = p + 1'b1;
        end else begin
            r.pos = p - 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dvd_motion_ctrl_if.sv
// Control/status bundle between the sprite motion controller and the video top level.
interface dvd_motion_ctrl_if;
    import dvd_pkg::*;

    logic               vsync;
    logic [SPEED_W-1:0] cfg_speed;
    logic               cfg_pause;
    logic               cfg_restart;
    logic [X_W-1:0]     pos_x;
    logic [Y_W-1:0]     pos_y;
    logic               dir_x;
    logic               dir_y;
    logic               step_strobe;
    logic               bounce;
    logic               corner;
    logic [COLOR_W-1:0] color_idx;

    modport master (
        output vsync, cfg_speed, cfg_pause, cfg_restart,
        input  pos_x, pos_y, dir_x, dir_y, step_strobe, bounce, corner, color_idx
    );

    modport slave (
        input  vsync, cfg_speed, cfg_pause, cfg_restart,
        output pos_x, pos_y, dir_x, dir_y, step_strobe, bounce, corner, color_idx
    );

endinterface

// File: rtl/dvd_frame_tick.sv
// Turns raw vsync into one tick per frame and divides ticks down to step requests.
module dvd_frame_tick
    import dvd_pkg::*;
#(
    parameter logic VS_ACTIVE = DEF_VS_ACTIVE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync_i,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic               pause_i,
    input  logic               restart_i,
    input  logic               en_i,
    output logic               step_req_o
);

    logic               vs_q;
    logic [SPEED_W-1:0] frame_cnt_q;
    logic [SPEED_W-1:0] frame_cnt_d;
    logic               tick;

    assign tick = (vsync_i == VS_ACTIVE) && (vs_q != VS_ACTIVE);

    // vs_q keeps tracking vsync through a restart so the dropped tick is not seen again.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        step_req_o  = 1'b0;
        if (restart_i) begin
            frame_cnt_d = '0;
        end else if (tick && en_i && !pause_i) begin
            if (frame_cnt_q >= speed_i) begin
                frame_cnt_d = '0;
                step_req_o  = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q        <= ~VS_ACTIVE;
            frame_cnt_q <= '0;
        end else begin
            vs_q        <= vsync_i;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/dvd_motion_ctrl.sv
// Bouncing sprite sequencer: steps position/direction on divided frame ticks and reports bounces.
module dvd_motion_ctrl
    import dvd_pkg::*;
#(
    parameter int   GRID_W    = DEF_GRID_W,
    parameter int   GRID_H    = DEF_GRID_H,
    parameter int   START_X   = DEF_START_X,
    parameter int   START_Y   = DEF_START_Y,
    parameter logic VS_ACTIVE = DEF_VS_ACTIVE
) (
    input  logic            clk,
    input  logic            reset,
    dvd_motion_ctrl_if.slave bus
);

    localparam logic [AXIS_W-1:0] MAX_X = AXIS_W'(GRID_W - 1);
    localparam logic [AXIS_W-1:0] MAX_Y = AXIS_W'(GRID_H - 1);
    localparam logic [AXIS_W-1:0] X0    = AXIS_W'(START_X);
    localparam logic [AXIS_W-1:0] Y0    = AXIS_W'(START_Y);

    state_t             state_q;
    logic [AXIS_W-1:0]  pos_x_q;
    logic [AXIS_W-1:0]  pos_y_q;
    logic               dir_x_q;
    logic               dir_y_q;
    logic               strobe_q;
    logic               bounce_q;
    logic               corner_q;
    logic [COLOR_W-1:0] color_q;
    logic               step_req;
    axis_t              x_nxt;
    axis_t              y_nxt;

    dvd_frame_tick #(
        .VS_ACTIVE (VS_ACTIVE)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .vsync_i    (bus.vsync),
        .speed_i    (bus.cfg_speed),
        .pause_i    (bus.cfg_pause),
        .restart_i  (bus.cfg_restart),
        .en_i       (state_q == IDLE),
        .step_req_o (step_req)
    );

    always_comb begin
        x_nxt = axis_step(pos_x_q, dir_x_q, MAX_X);
        y_nxt = axis_step(pos_y_q, dir_y_q, MAX_Y);
    end

    // Results and pulses are registered on leaving MOVE, so they are visible during REPORT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pos_x_q  <= X0;
            pos_y_q  <= Y0;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            strobe_q <= 1'b0;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
            color_q  <= '0;
        end else if (bus.cfg_restart) begin
            state_q  <= IDLE;
            pos_x_q  <= X0;
            pos_y_q  <= Y0;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            strobe_q <= 1'b0;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (step_req) state_q <= MOVE;
                end
                MOVE: begin
                    pos_x_q  <= x_nxt.pos;
                    pos_y_q  <= y_nxt.pos;
                    dir_x_q  <= x_nxt.dir;
                    dir_y_q  <= y_nxt.dir;
                    strobe_q <= 1'b1;
                    bounce_q <= x_nxt.flip | y_nxt.flip;
                    corner_q <= x_nxt.flip & y_nxt.flip;
                    color_q  <= color_q + {{(COLOR_W-1){1'b0}}, x_nxt.flip | y_nxt.flip};
                    state_q  <= REPORT;
                end
                REPORT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pos_x       = pos_x_q[X_W-1:0];
    assign bus.pos_y       = pos_y_q[Y_W-1:0];
    assign bus.dir_x       = dir_x_q;
    assign bus.dir_y       = dir_y_q;
    assign bus.step_strobe = strobe_q;
    assign bus.bounce      = bounce_q;
    assign bus.corner      = corner_q;
    assign bus.color_idx   = color_q;

endmodule
